// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - memory port handshake between the sequencer and the shared memory
interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic iord;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output iord, input mem_ready);
  modport slave  (input mem_req, input mem_we, input iord, output mem_ready);
endinterface

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle MIPS sequencer: FETCH/DECODE/EXEC/MEM/WB with bus timeout and illegal trap
module multicycle_ctrl #(
  parameter int ALUOP_W = 5,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        ins,
  input  logic               branch_taken,
  multicycle_ctrl_if.master  mem,
  output logic               ir_wr,
  output logic               pc_wr,
  output logic [1:0]         pc_src,
  output logic [2:0]         br_type,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               alu_src,
  output logic               ext_op,
  output logic               reg_dst,
  output logic               reg_l,
  output logic               reg_wr,
  output logic               mem_to_reg,
  output logic               illegal,
  output logic               bus_err,
  output logic [2:0]         state_o
);

  localparam logic [2:0] S_RST    = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_TRAP   = 3'd6;
  localparam logic [2:0] S_BERR   = 3'd7;

  localparam logic [3:0] K_BAD   = 4'd0;
  localparam logic [3:0] K_ALU_R = 4'd1;
  localparam logic [3:0] K_ALU_I = 4'd2;
  localparam logic [3:0] K_LOAD  = 4'd3;
  localparam logic [3:0] K_STORE = 4'd4;
  localparam logic [3:0] K_BR    = 4'd5;
  localparam logic [3:0] K_J     = 4'd6;
  localparam logic [3:0] K_JAL   = 4'd7;
  localparam logic [3:0] K_JR    = 4'd8;
  localparam logic [3:0] K_JALR  = 4'd9;

  localparam logic [4:0] A_ADD  = 5'h00;
  localparam logic [4:0] A_SUB  = 5'h01;
  localparam logic [4:0] A_SLT  = 5'h02;
  localparam logic [4:0] A_AND  = 5'h03;
  localparam logic [4:0] A_NOR  = 5'h04;
  localparam logic [4:0] A_OR   = 5'h05;
  localparam logic [4:0] A_XOR  = 5'h06;
  localparam logic [4:0] A_SLL  = 5'h07;
  localparam logic [4:0] A_SRL  = 5'h08;
  localparam logic [4:0] A_SLTU = 5'h09;
  localparam logic [4:0] A_LINK = 5'h0A;
  localparam logic [4:0] A_JR   = 5'h0B;
  localparam logic [4:0] A_SLLV = 5'h0C;
  localparam logic [4:0] A_SRA  = 5'h0D;
  localparam logic [4:0] A_SRAV = 5'h0E;
  localparam logic [4:0] A_SRLV = 5'h0F;
  localparam logic [4:0] A_LUI  = 5'h10;

  // TIMEOUT=0 still needs a one-bit counter so the flop is legal
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_q, illegal_d;
  logic             berr_q, berr_d;

  logic [5:0] op, fn;
  logic [4:0] rt;
  logic [3:0] kind;
  logic [4:0] d_alu;
  logic       d_src, d_ext, d_dst;
  logic [2:0] d_br;
  logic [4:0] alu5;
  logic       timed_out;
  logic       unused_ins;

  assign op = ins[31:26];
  assign fn = ins[5:0];
  assign rt = ins[20:16];
  assign unused_ins = ^{ins[25:21], ins[15:6]};

  always_comb begin
    kind  = K_BAD;
    d_alu = A_ADD;
    d_src = 1'b0;
    d_ext = 1'b0;
    d_dst = 1'b0;
    d_br  = 3'd0;
    case (op)
      6'h00: begin
        kind  = K_ALU_R;
        d_dst = 1'b1;
        case (fn)
          6'h00: d_alu = A_SLL;
          6'h02: d_alu = A_SRL;
          6'h03: d_alu = A_SRA;
          6'h04: d_alu = A_SLLV;
          6'h06: d_alu = A_SRLV;
          6'h07: d_alu = A_SRAV;
          6'h08: begin kind = K_JR; d_alu = A_JR; d_dst = 1'b0; end
          6'h09: begin kind = K_JALR; d_alu = A_LINK; end
          6'h20, 6'h21: d_alu = A_ADD;
          6'h22, 6'h23: d_alu = A_SUB;
          6'h24: d_alu = A_AND;
          6'h25: d_alu = A_OR;
          6'h26: d_alu = A_XOR;
          6'h27: d_alu = A_NOR;
          6'h2A: d_alu = A_SLT;
          6'h2B: d_alu = A_SLTU;
          default: kind = K_BAD;
        endcase
      end
      // REGIMM group: only BLTZ (rt=0) and BGEZ (rt=1) exist
      6'h01: begin
        kind = K_BR;
        if (rt == 5'd0)      d_br = 3'd5;
        else if (rt == 5'd1) d_br = 3'd6;
        else                 kind = K_BAD;
      end
      6'h02: kind = K_J;
      6'h03: kind = K_JAL;
      6'h04: begin kind = K_BR; d_br = 3'd1; d_alu = A_SUB; end
      6'h05: begin kind = K_BR; d_br = 3'd2; d_alu = A_SUB; end
      6'h06: begin kind = K_BR; d_br = 3'd3; end
      6'h07: begin kind = K_BR; d_br = 3'd4; end
      6'h08, 6'h09: begin kind = K_ALU_I; d_src = 1'b1; d_ext = 1'b1; end
      6'h0A: begin kind = K_ALU_I; d_src = 1'b1; d_ext = 1'b1; d_alu = A_SLT; end
      6'h0B: begin kind = K_ALU_I; d_src = 1'b1; d_alu = A_SLTU; end
      6'h0C: begin kind = K_ALU_I; d_src = 1'b1; d_alu = A_AND; end
      6'h0D: begin kind = K_ALU_I; d_src = 1'b1; d_alu = A_OR; end
      6'h0E: begin kind = K_ALU_I; d_src = 1'b1; d_alu = A_XOR; end
      6'h0F: begin kind = K_ALU_I; d_src = 1'b1; d_alu = A_LUI; end
      6'h20, 6'h23, 6'h24: begin kind = K_LOAD; d_src = 1'b1; d_ext = 1'b1; end
      6'h28, 6'h2B: begin kind = K_STORE; d_src = 1'b1; d_ext = 1'b1; end
      default: kind = K_BAD;
    endcase
  end

  // ready in the limit cycle is checked first, so TIMEOUT wait cycles are tolerated
  assign timed_out = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT));

  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    illegal_d   = illegal_q;
    berr_d      = berr_q;
    mem.mem_req = 1'b0;
    mem.mem_we  = 1'b0;
    mem.iord    = 1'b0;
    ir_wr       = 1'b0;
    pc_wr       = 1'b0;
    pc_src      = 2'd0;
    br_type     = 3'd0;
    alu5        = A_ADD;
    alu_src     = 1'b0;
    ext_op      = 1'b0;
    reg_dst     = 1'b0;
    reg_l       = 1'b0;
    reg_wr      = 1'b0;
    mem_to_reg  = 1'b0;
    case (state_q)
      S_RST: state_d = S_FETCH;
      S_FETCH: begin
        mem.mem_req = 1'b1;
        if (mem.mem_ready) begin
          ir_wr   = 1'b1;
          pc_wr   = 1'b1;
          state_d = S_DECODE;
        end else if (timed_out) begin
          state_d = S_BERR;
          berr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DECODE: begin
        case (kind)
          K_BAD: begin state_d = S_TRAP; illegal_d = 1'b1; end
          K_J: begin pc_wr = 1'b1; pc_src = 2'd2; state_d = S_FETCH; end
          K_JAL: begin
            pc_wr   = 1'b1;
            pc_src  = 2'd2;
            reg_wr  = 1'b1;
            reg_l   = 1'b1;
            alu5    = A_LINK;
            state_d = S_FETCH;
          end
          default: state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        alu5    = d_alu;
        alu_src = d_src;
        ext_op  = d_ext;
        reg_dst = d_dst;
        case (kind)
          K_BR: begin
            br_type = d_br;
            pc_wr   = branch_taken;
            pc_src  = 2'd1;
            state_d = S_FETCH;
          end
          K_JR: begin pc_wr = 1'b1; pc_src = 2'd3; state_d = S_FETCH; end
          K_JALR: begin
            pc_wr   = 1'b1;
            pc_src  = 2'd3;
            reg_wr  = 1'b1;
            reg_l   = 1'b1;
            state_d = S_FETCH;
          end
          K_LOAD, K_STORE: state_d = S_MEM;
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        mem.mem_req = 1'b1;
        mem.iord    = 1'b1;
        mem.mem_we  = (kind == K_STORE);
        if (mem.mem_ready) begin
          state_d = (kind == K_STORE) ? S_FETCH : S_WB;
        end else if (timed_out) begin
          state_d = S_BERR;
          berr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WB: begin
        reg_wr     = 1'b1;
        mem_to_reg = (kind == K_LOAD);
        reg_dst    = d_dst;
        state_d    = S_FETCH;
      end
      S_TRAP, S_BERR: state_d = state_q;
      default: state_d = S_RST;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_RST;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      berr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      berr_q    <= berr_d;
    end
  end

  assign alu_op  = ALUOP_W'(alu5);
  assign illegal = illegal_q;
  assign bus_err = berr_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed-vector bench for the multi-cycle sequencer
module tb_multicycle_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ins = 32'h0;
  logic        branch_taken = 1'b0;
  logic        ir_wr, pc_wr, alu_src, ext_op, reg_dst, reg_l, reg_wr, mem_to_reg;
  logic        illegal, bus_err;
  logic [1:0]  pc_src;
  logic [2:0]  br_type, state_o;
  logic [4:0]  alu_op;
  logic [19:0] ctl_v;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  multicycle_ctrl_if mif ();

  multicycle_ctrl #(.ALUOP_W(5), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .ins(ins), .branch_taken(branch_taken), .mem(mif),
    .ir_wr(ir_wr), .pc_wr(pc_wr), .pc_src(pc_src), .br_type(br_type), .alu_op(alu_op),
    .alu_src(alu_src), .ext_op(ext_op), .reg_dst(reg_dst), .reg_l(reg_l), .reg_wr(reg_wr),
    .mem_to_reg(mem_to_reg), .illegal(illegal), .bus_err(bus_err), .state_o(state_o)
  );

  always #5 clk = ~clk;

  assign ctl_v = {mif.mem_req, mif.mem_we, mif.iord, ir_wr, pc_wr, pc_src, br_type, alu_op,
                  alu_src, ext_op, reg_dst, reg_l, reg_wr, mem_to_reg};

  function automatic logic [19:0] ctl(input logic mreq, input logic we, input logic io,
                                      input logic irw, input logic pcw, input logic [1:0] ps,
                                      input logic [2:0] bt, input logic [4:0] ao,
                                      input logic as, input logic eo, input logic rd,
                                      input logic rl, input logic rw, input logic m2r);
    return {mreq, we, io, irw, pcw, ps, bt, ao, as, eo, rd, rl, rw, m2r};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    ins = 32'h00221821;
    mif.mem_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++;
    if (ctl_v !== 20'h0) $display("FAIL reset_ctl got %h want %h", ctl_v, 20'h0);
    else pass_cnt++;
    total_cnt++;
    if ({illegal, bus_err, state_o} !== 5'b0)
      $display("FAIL reset_flags got %b want 00000", {illegal, bus_err, state_o});
    else pass_cnt++;
    rst_n = 1'b1;
    @(posedge clk); #1 mif.mem_ready = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({state_o, mif.mem_req} !== {3'd1, 1'b1})
      $display("FAIL fetch_after_release got %0d/%b want 1/1", state_o, mif.mem_req);
    else pass_cnt++;
    #1 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({state_o, mif.mem_req} !== {3'd0, 1'b0})
      $display("FAIL async_reset_drop got %0d/%b want 0/0", state_o, mif.mem_req);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_alu();
    logic [2:0]  es[5];
    logic [19:0] ec[5];
    es = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd1};
    ec = '{ctl(1,0,0,1,1,2'd0,3'd0,5'h00,0,0,0,0,0,0), 20'h0,
           ctl(0,0,0,0,0,2'd0,3'd0,5'h00,0,0,1,0,0,0),
           ctl(0,0,0,0,0,2'd0,3'd0,5'h00,0,0,1,0,1,0),
           ctl(1,0,0,1,1,2'd0,3'd0,5'h00,0,0,0,0,0,0)};
    ins = 32'h00221821;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1 mif.mem_ready = 1'b1;
      @(negedge clk);
      total_cnt++;
      if ({state_o, ctl_v} !== {es[i], ec[i]})
        $display("FAIL addu_cyc%0d state %0d ctl %h want state %0d ctl %h", i, state_o, ctl_v, es[i], ec[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_load();
    logic [2:0]  es[12];
    logic [19:0] ec[12];
    logic        rd[12];
    logic [19:0] fw, fg, mm;
    fw = ctl(1,0,0,0,0,2'd0,3'd0,5'h00,0,0,0,0,0,0);
    fg = ctl(1,0,0,1,1,2'd0,3'd0,5'h00,0,0,0,0,0,0);
    mm = ctl(1,0,1,0,0,2'd0,3'd0,5'h00,0,0,0,0,0,0);
    es = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4, 3'd5, 3'd1};
    rd = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    ec = '{fw, fw, fw, fg, 20'h0, ctl(0,0,0,0,0,2'd0,3'd0,5'h00,1,1,0,0,0,0), mm, mm, mm, mm,
           ctl(0,0,0,0,0,2'd0,3'd0,5'h00,0,0,0,0,1,1), fg};
    ins = 32'h8C250004;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1 mif.mem_ready = rd[i];
      @(negedge clk);
      total_cnt++;
      if ({state_o, ctl_v} !== {es[i], ec[i]})
        $display("FAIL lw_cyc%0d state %0d ctl %h want state %0d ctl %h", i, state_o, ctl_v, es[i], ec[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_store();
    logic [2:0]  es[5];
    logic [19:0] ec[5];
    es = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd1};
    ec = '{ctl(1,0,0,1,1,2'd0,3'd0,5'h00,0,0,0,0,0,0), 20'h0,
           ctl(0,0,0,0,0,2'd0,3'd0,5'h00,1,1,0,0,0,0),
           ctl(1,1,1,0,0,2'd0,3'd0,5'h00,0,0,0,0,0,0),
           ctl(1,0,0,1,1,2'd0,3'd0,5'h00,0,0,0,0,0,0)};
    ins = 32'hAC250008;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1 mif.mem_ready = 1'b1;
      @(negedge clk);
      total_cnt++;
      if ({state_o, ctl_v} !== {es[i], ec[i]})
        $display("FAIL sw_cyc%0d state %0d ctl %h want state %0d ctl %h", i, state_o, ctl_v, es[i], ec[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_branch();
    logic [2:0]  es[7];
    logic [19:0] ec[7];
    logic        tk[7];
    logic [19:0] fg;
    fg = ctl(1,0,0,1,1,2'd0,3'd0,5'h00,0,0,0,0,0,0);
    es = '{3'd1, 3'd2, 3'd3, 3'd1, 3'd2, 3'd3, 3'd1};
    tk = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    ec = '{fg, 20'h0, ctl(0,0,0,0,1,2'd1,3'd1,5'h01,0,0,0,0,0,0), fg, 20'h0,
           ctl(0,0,0,0,0,2'd1,3'd1,5'h01,0,0,0,0,0,0), fg};
    ins = 32'h10220003;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1 mif.mem_ready = 1'b1; branch_taken = tk[i];
      @(negedge clk);
      total_cnt++;
      if ({state_o, ctl_v} !== {es[i], ec[i]})
        $display("FAIL beq_cyc%0d state %0d ctl %h want state %0d ctl %h", i, state_o, ctl_v, es[i], ec[i]);
      else pass_cnt++;
    end
    branch_taken = 1'b0;
  endtask

  task automatic test_jal();
    logic [2:0]  es[3];
    logic [19:0] ec[3];
    es = '{3'd1, 3'd2, 3'd1};
    ec = '{ctl(1,0,0,1,1,2'd0,3'd0,5'h00,0,0,0,0,0,0),
           ctl(0,0,0,0,1,2'd2,3'd0,5'h0A,0,0,0,1,1,0),
           ctl(1,0,0,1,1,2'd0,3'd0,5'h00,0,0,0,0,0,0)};
    ins = 32'h0C000010;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1 mif.mem_ready = 1'b1;
      @(negedge clk);
      total_cnt++;
      if ({state_o, ctl_v} !== {es[i], ec[i]})
        $display("FAIL jal_cyc%0d state %0d ctl %h want state %0d ctl %h", i, state_o, ctl_v, es[i], ec[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_trap();
    ins = 32'hFC000000;
    do_reset();
    repeat (2) begin
      @(posedge clk); #1 mif.mem_ready = 1'b1;
    end
    @(negedge clk);
    total_cnt++;
    if ({state_o, illegal} !== {3'd2, 1'b0})
      $display("FAIL trap_decode state %0d illegal %b want 2/0", state_o, illegal);
    else pass_cnt++;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total_cnt++;
      if ({state_o, illegal, ctl_v} !== {3'd6, 1'b1, 20'h0})
        $display("FAIL trap_hold%0d state %0d illegal %b ctl %h want 6/1/00000", i, state_o, illegal, ctl_v);
      else pass_cnt++;
    end
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({state_o, illegal} !== {3'd0, 1'b0})
      $display("FAIL trap_clear state %0d illegal %b want 0/0", state_o, illegal);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (state_o !== 3'd1) $display("FAIL trap_release state %0d want 1", state_o);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    ins = 32'h00221821;
    do_reset();
    for (int i = 0; i < 18; i++) begin
      @(posedge clk); #1 mif.mem_ready = 1'b0;
      @(negedge clk);
      if (i < 17) begin
        total_cnt++;
        if ({state_o, bus_err, mif.mem_req} !== {3'd1, 1'b0, 1'b1})
          $display("FAIL berr_wait%0d state %0d bus_err %b req %b want 1/0/1", i, state_o, bus_err, mif.mem_req);
        else pass_cnt++;
      end else begin
        total_cnt++;
        if ({state_o, bus_err, ctl_v} !== {3'd7, 1'b1, 20'h0})
          $display("FAIL berr_enter state %0d bus_err %b ctl %h want 7/1/00000", state_o, bus_err, ctl_v);
        else pass_cnt++;
      end
    end
    do_reset();
    for (int i = 0; i < 18; i++) begin
      @(posedge clk); #1 mif.mem_ready = (i == 16);
      @(negedge clk);
    end
    total_cnt++;
    if ({state_o, bus_err} !== {3'd2, 1'b0})
      $display("FAIL ready_at_limit state %0d bus_err %b want 2/0", state_o, bus_err);
    else pass_cnt++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired after %0d checks", total_cnt);
    $fatal(1);
  end

  initial begin
    mif.mem_ready = 1'b0;
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_branch();
    test_jal();
    test_trap();
    test_timeout();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Sequencing control unit for the multi-cycle MIPS core. Successor to the single-cycle combinational decoder.
- Decodes the same instruction subset and sequences each instruction through FETCH/DECODE/EXEC/MEM/WB, sharing one ALU and one memory port.
- Adds a variable-latency memory handshake, a bounded-wait bus timeout, and an illegal-opcode trap.
- Sits between the instruction register and the datapath muxes, PC, register file and memory port.

Parameters:
- ALUOP_W, 5, alu_op width; must be at least 5.
- TIMEOUT, 16, maximum wait cycles for mem_ready before a bus error; 0 disables the timeout.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- ins  in  32  current IR contents; stable from DECODE onward.
- mem_ready  in  1  memory accepts/returns this cycle.
- branch_taken  in  1  datapath condition result for br_type; valid in EXEC.
- mem_req  out  1  memory access request.
- mem_we  out  1  store when 1.
- iord  out  1  address select: 0 = PC, 1 = ALU result.
- ir_wr  out  1  load IR from memory data.
- pc_wr  out  1  PC write enable.
- pc_src  out  2  PC source: 0 = PC+4, 1 = branch target, 2 = jump target, 3 = rs.
- br_type  out  3  branch type: 0 none, 1 BEQ, 2 BNE, 3 BLEZ, 4 BGTZ, 5 BLTZ, 6 BGEZ.
- alu_op  out  ALUOP_W  ALU operation: 00 ADD, 01 SUB, 02 SLT, 03 AND, 04 NOR, 05 OR, 06 XOR, 07 SLL, 08 SRL, 09 SLTU, 0A LINK, 0B JR, 0C SLLV, 0D SRA, 0E SRAV, 0F SRLV, 10 LUI.
- alu_src  out  1  ALU B operand: 0 = rt, 1 = immediate.
- ext_op  out  1  immediate extension: 1 = sign-extend, 0 = zero-extend.
- reg_dst  out  1  destination register: 1 = rd, 0 = rt.
- reg_l  out  1  write link address (PC+4; $31 for JAL, rd for JALR).
- reg_wr  out  1  register file write enable.
- mem_to_reg  out  1  write-back data select: 1 = memory data.
- illegal  out  1  sticky flag: undefined op/func decoded.
- bus_err  out  1  sticky flag: memory timeout.
- state_o  out  3  current state, for debug.

Behaviour:
- States:
  - RST=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6, BERR=7.
  - Registered state and wait counter of width clog2(TIMEOUT+1); all outputs decoded combinationally from state and ins.
- Reset:
  - rst_n low forces state RST and clears the counter, illegal and bus_err, asynchronously.
  - In RST every output is 0. First clock edge with rst_n high moves to FETCH.
  - Reset mid-access drops mem_req immediately.
- FETCH:
  - mem_req=1, iord=0.
  - When mem_ready=1 in the same cycle: ir_wr=1, pc_wr=1, pc_src=0, next state DECODE.
  - Zero-wait memory (ready in the first cycle) is legal.
- DECODE (one cycle):
  - Undefined op or R-func -> TRAP. BLTZ-group with rt other than 0 or 1 is undefined.
  - J: pc_wr=1, pc_src=2 -> FETCH.
  - JAL: pc_wr=1, pc_src=2, reg_wr=1, reg_l=1, alu_op=0A -> FETCH.
  - All other instructions -> EXEC.
- EXEC:
  - ALU, extend and destination controls per opcode:
    - I-type arithmetic: alu_src=1.
    - ADDIU, SLTI and all loads/stores: ext_op=1.
    - ANDI, ORI, XORI, SLTIU, LUI: ext_op=0.
    - R-type: reg_dst=1.
  - Branches: alu_op=SUB for BEQ/BNE, ADD otherwise; br_type set; pc_wr=branch_taken, pc_src=1 -> FETCH.
  - JR: pc_wr=1, pc_src=3 -> FETCH.
  - JALR: additionally reg_wr=1, reg_l=1, reg_dst=1 -> FETCH.
  - R-type and I-type ALU ops -> WB.
  - LW, LB, LBU, SW, SB -> MEM with alu_op=ADD.
- MEM:
  - mem_req=1, iord=1, mem_we=1 for stores.
  - On mem_ready: store -> FETCH; load -> WB.
- WB: reg_wr=1; mem_to_reg=1 for loads; reg_dst held from the EXEC decode -> FETCH.
- Cycle counts with zero-wait memory: J/JAL 2; branch/JR/JALR 3; ALU op 4; store 4; load 5.
- Timeout:
  - Counter clears on entering FETCH/MEM and on any mem_ready.
  - Counter increments each FETCH/MEM cycle with mem_ready=0.
  - When the counter reaches TIMEOUT with ready still low -> BERR.
  - mem_ready in the limit cycle wins, i.e. TIMEOUT wait cycles are tolerated.
  - TIMEOUT=0 means wait forever.
- TRAP: illegal=1, all enables 0, held until reset.
- BERR: bus_err=1, all enables 0, held until reset.
- The decoder never asserts mem_we and reg_wr in the same cycle, and never asserts pc_wr outside FETCH/DECODE/EXEC.

Test Plan:
- Reset release, zero-wait memory, ins=ADDU $3,$1,$2 (0x00221821) -> states 1,2,3,5,1; alu_op=00, reg_dst=1, reg_wr=1 only in WB.
- LW $5,4($1) (0x8C250004), mem_ready delayed 3 cycles in both FETCH and MEM -> FETCH held 4 cycles; WB with mem_to_reg=1, reg_wr=1; 11 cycles total.
- BEQ with branch_taken=1, then with branch_taken=0 -> EXEC shows br_type=1, alu_op=01; pc_wr=1/pc_src=1 on taken, pc_wr=0 on not taken; both return to FETCH after 3 cycles.
- JAL (0x0C000010) -> DECODE asserts pc_wr, pc_src=2, reg_wr, reg_l, alu_op=0A; next state FETCH.
- ins=0xFC000000 -> TRAP after DECODE; illegal=1 persists 20 cycles; rst_n pulse clears it; state_o=1 after release.
- TIMEOUT=16, mem_ready low forever in FETCH -> BERR after 17 FETCH cycles with bus_err=1. Rerun with mem_ready in the 17th cycle -> DECODE and no error.
